aes_run_sequencer: RTL

//  Sequences the AES core for side-channel capture campaigns: loads the key once, issues
//  NUM encryptions back-to-back (fixed plaintext or ciphertext-chained), captures each

---
 rtl/aes_run_sequencer_if.sv | 39 +++
 rtl/aes_run_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_run_sequencer_if.sv
// Control, status and AES-core handshake bundle for the capture-campaign sequencer.
// master is the sequencer's view; slave is the register file / core / bench view.
interface aes_run_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start_i;
   logic             abort_i;
   logic             chain_i;
   logic [CNT_W-1:0] num_runs_i;
   logic [127:0]     key_i;
   logic [127:0]     pt_i;
   logic [127:0]     aes_key_o;
   logic [127:0]     aes_din_o;
   logic             aes_krdy_o;
   logic             aes_drdy_o;
   logic             aes_kvld_i;
   logic             aes_dvld_i;
   logic [127:0]     aes_dout_i;
   logic [127:0]     ct_o;
   logic [CNT_W-1:0] run_cnt_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic             trig_o;

   modport master (
      input  start_i, abort_i, chain_i, num_runs_i, key_i, pt_i,
      input  aes_kvld_i, aes_dvld_i, aes_dout_i,
      output aes_key_o, aes_din_o, aes_krdy_o, aes_drdy_o,
      output ct_o, run_cnt_o, busy_o, done_o, err_o, trig_o
   );

   modport slave (
      output start_i, abort_i, chain_i, num_runs_i, key_i, pt_i,
      output aes_kvld_i, aes_dvld_i, aes_dout_i,
      input  aes_key_o, aes_din_o, aes_krdy_o, aes_drdy_o,
      input  ct_o, run_cnt_o, busy_o, done_o, err_o, trig_o
   );
endinterface

// File: rtl/aes_run_sequencer.sv
// Drives an AES core through one key load and num_runs back-to-back encryptions,
// capturing each ciphertext and framing every encryption with a scope trigger.
module aes_run_sequencer #(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic                 ACLK,
   input logic                 ARESETN,
   aes_run_sequencer_if.master bus
);

   localparam int              TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEY   = 3'd1,
      ST_KWAIT = 3'd2,
      ST_DATA  = 3'd3,
      ST_DWAIT = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   state_e           state_q;
   logic [127:0]     key_q;
   logic [127:0]     din_q;
   logic [127:0]     ct_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] run_cnt_q;
   logic [CNT_W-1:0] run_cnt_d;
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit_d;
   logic             chain_q;
   logic             krdy_q;
   logic             drdy_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             trig_q;

   // Next run count and timeout-expiry decode
   always_comb begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
      tmo_hit_d = (tmo_q == TMO_LAST);
   end

   // Sequencer FSM; every output is a register updated alongside the state
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= ST_IDLE;
         key_q     <= 128'h0;
         din_q     <= 128'h0;
         ct_q      <= 128'h0;
         num_q     <= '0;
         run_cnt_q <= '0;
         tmo_q     <= '0;
         chain_q   <= 1'b0;
         krdy_q    <= 1'b0;
         drdy_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         trig_q    <= 1'b0;
      end else begin
         krdy_q <= 1'b0;
         drdy_q <= 1'b0;
         done_q <= 1'b0;
         if (bus.abort_i) begin
            // abort outranks valids and timeout; captured results stay visible
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            trig_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.start_i) begin
                     key_q     <= bus.key_i;
                     din_q     <= bus.pt_i;
                     num_q     <= bus.num_runs_i;
                     chain_q   <= bus.chain_i;
                     run_cnt_q <= '0;
                     err_q     <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= (bus.num_runs_i == '0) ? ST_FIN : ST_KEY;
                  end
               end
               ST_KEY: begin
                  krdy_q  <= 1'b1;
                  tmo_q   <= '0;
                  state_q <= ST_KWAIT;
               end
               ST_KWAIT: begin
                  if (bus.aes_kvld_i) begin
                     state_q <= ST_DATA;
                  end else if (tmo_hit_d) begin
                     err_q   <= 1'b1;
                     trig_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end
               ST_DATA: begin
                  drdy_q  <= 1'b1;
                  trig_q  <= 1'b1;
                  tmo_q   <= '0;
                  state_q <= ST_DWAIT;
               end
               ST_DWAIT: begin
                  if (bus.aes_dvld_i) begin
                     ct_q      <= bus.aes_dout_i;
                     run_cnt_q <= run_cnt_d;
                     trig_q    <= 1'b0;
                     if (chain_q) begin
                        din_q <= bus.aes_dout_i;
                     end
                     state_q <= (run_cnt_d == num_q) ? ST_FIN : ST_DATA;
                  end else if (tmo_hit_d) begin
                     err_q   <= 1'b1;
                     trig_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end
               ST_FIN: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  trig_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.aes_key_o  = key_q;
   assign bus.aes_din_o  = din_q;
   assign bus.aes_krdy_o = krdy_q;
   assign bus.aes_drdy_o = drdy_q;
   assign bus.ct_o       = ct_q;
   assign bus.run_cnt_o  = run_cnt_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.err_o      = err_q;
   assign bus.trig_o     = trig_q;

endmodule
